// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter: a grant is locked to one owner until release or
// until the hold counter reaches MAX_HOLD, which forces release with a timeout pulse.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic [7:0]       req_i,
  input  logic             release_i,
  output logic             grant_valid_o,
  output logic [2:0]       grant_idx_o,
  output logic             timeout_o,
  output logic [0:0]       state_o
);

  // Handshake: while grant_valid_o=1, grant_idx_o names the owner; the owner
  // ends its tenure by asserting release_i for one cycle, sampled on the rising edge.

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  // With the timeout disabled the counter still must not wrap, so it saturates at all-ones.
  localparam logic [CNT_W-1:0] HOLD_SAT   = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [2:0]       winner;
  logic             has_req;
  logic             at_limit;

  // Scans from last+8 (== last) down to last+1 so the lowest offset is kept,
  // which leaves the previous owner as the lowest-priority candidate.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = last;
    for (int k = 8; k >= 1; k--) begin
      idx = last + 3'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign winner   = rr_pick(req_i, last_q);
  assign has_req  = |req_i;
  assign at_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (has_req) begin
          state_d    = ST_GRANT;
          idx_d      = winner;
          last_d     = winner;
          hold_cnt_d = CNT_ONE;
        end
      end
      ST_GRANT: begin
        if (release_i || at_limit) begin
          timeout_d = !release_i;
          if (has_req) begin
            idx_d      = winner;
            last_d     = winner;
            hold_cnt_d = CNT_ONE;
          end else begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      last_q     <= 3'd7;
      idx_q      <= 3'd0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_valid_o = (state_q == ST_GRANT);
  assign grant_idx_o   = idx_q;
  assign timeout_o     = timeout_q;
  assign state_o       = state_q;

endmodule
